pwm_duty_ramp: RTL and testbench

PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

---
 rtl/pwm_duty_ramp.sv | 138 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
//   Selects the duty code for a downstream PWM from four slide switches.
//   The switch vector is synchronized, debounced as a whole, and the
//   accepted value (target) is either jumped to or slewed toward one code
//   per step. The duty code only ever changes at the end of a PWM period,
//   so every period runs with a single constant code.
//
// Ports
//   clk          sole clock
//   rst_n        synchronous active-low reset
//   sw_raw[3:0]  raw asynchronous switches
//   ramp_en      1 = slew one code per step, 0 = jump to target at period end
//   duty_code    duty select for the downstream PWM
//   period_start high in the first cycle of every PWM period
//   busy         duty_code has not yet reached the accepted switch value
//
// state | meaning
// ------+--------------------------------------
// IDLE  | duty_code == target, nothing to do
// UP    | duty_code <  target, next step adds 1
// DOWN  | duty_code >  target, next step subtracts 1

module pwm_duty_ramp #(
    parameter int CBITS        = 14,
    parameter int DEB_CYCLES   = 16,
    parameter int STEP_PERIODS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_raw,
    input  logic       ramp_en,
    output logic [3:0] duty_code,
    output logic       period_start,
    output logic       busy
);

    localparam int DBITS = $clog2(DEB_CYCLES);
    localparam int SBITS = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [DBITS-1:0] DEB_LAST  = DBITS'(DEB_CYCLES - 1);
    localparam logic [SBITS-1:0] STEP_LAST = SBITS'(STEP_PERIODS - 1);
    localparam logic [CBITS-1:0] PCNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       candidate;
    logic [DBITS-1:0] deb_cnt;
    logic [3:0]       target;
    logic [CBITS-1:0] pcnt;
    logic [SBITS-1:0] step_cnt;
    state_t           state;

    logic             wrap;
    logic             step_evt;
    logic [3:0]       target_nxt;
    logic [3:0]       duty_nxt;
    logic [SBITS-1:0] step_nxt;

    function automatic state_t classify(input logic [3:0] d, input logic [3:0] t);
        if (d < t)      return UP;
        else if (d > t) return DOWN;
        else            return IDLE;
    endfunction

    assign wrap     = (pcnt == PCNT_LAST);
    assign step_evt = wrap && (step_cnt == STEP_LAST);

    // Both outputs are forced low while reset is held, even before the
    // first reset edge has cleared the registers.
    assign period_start = rst_n && (pcnt == '0);
    assign busy         = rst_n && (duty_code != target);

    always_comb begin
        target_nxt = target;
        duty_nxt   = duty_code;
        step_nxt   = step_cnt;

        if ((sync2 == candidate) && (deb_cnt == DEB_LAST)) begin
            target_nxt = candidate;
        end

        // Steps are decided from the registered state, i.e. against the
        // target as it stood before this edge.
        if (wrap) begin
            if (ramp_en) begin
                step_nxt = step_evt ? '0 : step_cnt + 1'b1;
                if (step_evt) begin
                    case (state)
                        UP:      duty_nxt = duty_code + 4'd1;
                        DOWN:    duty_nxt = duty_code - 4'd1;
                        default: duty_nxt = duty_code;
                    endcase
                end
            end else begin
                duty_nxt = target;
                step_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            deb_cnt   <= '0;
            target    <= '0;
            pcnt      <= '0;
            step_cnt  <= '0;
            duty_code <= '0;
            state     <= IDLE;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;

            if (sync2 != candidate) begin
                candidate <= sync2;
                deb_cnt   <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            target    <= target_nxt;
            pcnt      <= pcnt + 1'b1;
            step_cnt  <= step_nxt;
            duty_code <= duty_nxt;
            // Keep state consistent with the registers it describes.
            state     <= classify(duty_nxt, target_nxt);
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp
//   Two instances with CBITS=4, DEB_CYCLES=4: dut_a with STEP_PERIODS=1
//   driven from a vector table, dut_b with STEP_PERIODS=3 driven by a
//   hand-written sequence. Inputs change and outputs are sampled just
//   after the falling edge; vector "adv" counts rising edges to advance.

module tb_pwm_duty_ramp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_ramp, a_ps, a_busy;
    logic [3:0] a_sw, a_duty;
    logic       b_rst_n, b_ramp, b_ps, b_busy;
    logic [3:0] b_sw, b_duty;

    pwm_duty_ramp #(.CBITS(4), .DEB_CYCLES(4), .STEP_PERIODS(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .sw_raw(a_sw), .ramp_en(a_ramp),
        .duty_code(a_duty), .period_start(a_ps), .busy(a_busy)
    );

    pwm_duty_ramp #(.CBITS(4), .DEB_CYCLES(4), .STEP_PERIODS(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .sw_raw(b_sw), .ramp_en(b_ramp),
        .duty_code(b_duty), .period_start(b_ps), .busy(b_busy)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] sw;
        logic       ramp;
        int         adv;
        logic [3:0] duty;
        logic       busy;
        logic       ps;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] s, input logic rm, input int n,
                       input logic [3:0] d, input logic b, input logic p);
        vec_t v;
        v.rst_n = r; v.sw = s; v.ramp = rm; v.adv = n;
        v.duty = d; v.busy = b; v.ps = p;
        vecs.push_back(v);
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk_b(input string name, input logic [3:0] d, input logic b, input logic p);
        chk({name, " duty"}, b_duty, d);
        chk({name, " busy"}, {3'b000, b_busy}, {3'b000, b});
        chk({name, " ps"},   {3'b000, b_ps},   {3'b000, p});
    endtask

    initial begin
        a_rst_n = 1'b0; a_sw = 4'd0; a_ramp = 1'b1;
        b_rst_n = 1'b0; b_sw = 4'd0; b_ramp = 1'b1;

        // Comments give c = rising edges since reset release at the check.
        //  rst  sw   ramp adv duty busy ps
        add(0, 0,  1, 3,  0, 0, 0);   // held in reset
        add(1, 0,  1, 0,  0, 0, 1);   // c=0
        add(1, 0,  1, 1,  0, 0, 0);   // c=1
        add(1, 0,  1, 15, 0, 0, 1);   // c=16
        add(1, 0,  1, 16, 0, 0, 1);   // c=32
        add(1, 9,  1, 3,  0, 0, 0);   // c=35 glitch of 3 cycles
        add(1, 0,  1, 5,  0, 0, 0);   // c=40
        add(1, 0,  1, 8,  0, 0, 1);   // c=48
        add(1, 3,  1, 6,  0, 0, 0);   // c=54 one edge before acceptance
        add(1, 3,  1, 1,  0, 1, 0);   // c=55 target=3
        add(1, 3,  1, 8,  0, 1, 0);   // c=63
        add(1, 3,  1, 1,  1, 1, 1);   // c=64
        add(1, 3,  1, 16, 2, 1, 1);   // c=80
        add(1, 3,  1, 15, 2, 1, 0);   // c=95
        add(1, 3,  1, 1,  3, 0, 1);   // c=96
        add(1, 3,  1, 16, 3, 0, 1);   // c=112 idle hold
        add(1, 2,  0, 7,  3, 1, 0);   // c=119 jump mode, target=2
        add(1, 2,  0, 9,  2, 0, 1);   // c=128
        add(1, 15, 0, 7,  2, 1, 0);   // c=135 target=15
        add(1, 15, 0, 8,  2, 1, 0);   // c=143
        add(1, 15, 0, 1,  15, 0, 1);  // c=144 jump 2->15
        add(1, 0,  0, 7,  15, 1, 0);  // c=151
        add(1, 0,  0, 9,  0, 0, 1);   // c=160
        add(1, 12, 1, 16, 1, 1, 1);   // c=176 ramp toward 12
        add(1, 12, 1, 64, 5, 1, 1);   // c=240
        add(1, 12, 1, 16, 6, 1, 1);   // c=256
        add(1, 4,  1, 7,  6, 1, 0);   // c=263 target=4 mid-ramp
        add(1, 4,  1, 9,  5, 1, 1);   // c=272 reversed
        add(1, 4,  1, 16, 4, 0, 1);   // c=288
        add(1, 4,  1, 16, 4, 0, 1);   // c=304 idle
        add(1, 4,  1, 9,  4, 0, 0);   // c=313
        add(1, 10, 1, 6,  4, 0, 0);   // c=319
        add(1, 10, 1, 1,  4, 1, 1);   // c=320 target update on wrap edge: old target wins
        add(1, 10, 1, 16, 5, 1, 1);   // c=336

        for (int i = 0; i < vecs.size(); i++) begin
            a_rst_n = vecs[i].rst_n;
            a_sw    = vecs[i].sw;
            a_ramp  = vecs[i].ramp;
            if (vecs[i].adv > 0) repeat (vecs[i].adv) @(negedge clk);
            #1;
            chk($sformatf("v%0d duty", i), a_duty, vecs[i].duty);
            chk($sformatf("v%0d busy", i), {3'b000, a_busy}, {3'b000, vecs[i].busy});
            chk($sformatf("v%0d ps", i),   {3'b000, a_ps},   {3'b000, vecs[i].ps});
        end

        // dut_b: STEP_PERIODS=3, has been in reset since time 0.
        chk_b("b_rst", 0, 0, 0);
        b_rst_n = 1'b1;
        b_sw    = 4'd2;
        #1;
        chk_b("b_c0", 0, 0, 1);
        adv(16); chk_b("b_c16", 0, 1, 1);
        adv(16); chk_b("b_c32", 0, 1, 1);
        adv(15); chk_b("b_c47", 0, 1, 0);
        adv(1);  chk_b("b_c48", 1, 1, 1);
        adv(16); chk_b("b_c64", 1, 1, 1);
        adv(16); chk_b("b_c80", 1, 1, 1);
        adv(16); chk_b("b_c96", 2, 0, 1);
        b_sw = 4'd12;
        adv(54); chk_b("b_c150", 3, 1, 0);
        b_rst_n = 1'b0;
        adv(1);  chk_b("b_rst_mid", 0, 0, 0);
        b_rst_n = 1'b1;
        #1;
        chk_b("b_r0", 0, 0, 1);
        adv(6);  chk_b("b_r6", 0, 0, 0);
        adv(1);  chk_b("b_r7", 0, 1, 0);
        adv(9);  chk_b("b_r16", 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
